// File: rtl/addsub_seq_flags.sv
// addsub_seq_flags
//   Multi-cycle add/subtract unit. Processes WIDTH-bit operands CHUNK bits per
//   clock, LSB first, and keeps a registered Z/C/V/N flag set. ADC/SBC seed the
//   carry from the stored C flag so wider words can be chained.
//
//   Optional feature: define ADDSUB_SAT_EN to add one SAT cycle that clamps
//   signed-overflowed results (latency K+1 instead of K, K = WIDTH/CHUNK).
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while busy=0
//   op     : 00=ADD 01=SUB 10=ADC 11=SBC
//   a, b   : operands, latched on accept
//   busy   : operation in progress
//   done   : one-cycle pulse, y and flags updated
//   y      : result, held until next done
//   z/c/v/n: zero / carry (1 = no borrow on SUB/SBC) / signed overflow / sign
module addsub_seq_flags #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             n
);

  localparam int K  = WIDTH / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

`ifdef ADDSUB_SAT_EN
  typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t            state;
  logic [WIDTH-1:0]  a_r;       // operand A, shifted right one chunk per cycle
  logic [WIDTH-1:0]  b_r;       // operand B' (inverted for SUB/SBC), shifted likewise
  logic              carry_r;   // running carry between chunks
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  acc_r;     // result assembled from the top down

  logic [CHUNK:0]    csum;
  logic [WIDTH-1:0]  ext;
  logic [WIDTH-1:0]  acc_next;
  logic              cout;
  logic              cin_msb;
  logic              ovf;
  logic              last;

  always_comb begin
    csum     = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK+1)'(carry_r);
    // Each new chunk enters at the top and the accumulator shifts right, so
    // after K chunks the first one has landed at bit 0.
    ext      = WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK);
    acc_next = (acc_r >> CHUNK) | ext;
    cout     = csum[CHUNK];
    // On the last chunk, bit CHUNK-1 of the shifted operands is the word MSB;
    // recover the carry into it from the sum bit.
    cin_msb  = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ csum[CHUNK-1];
    ovf      = cin_msb ^ cout;
    last     = (cnt == CW'(K - 1));
  end

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             sat_c;
  logic             sat_v;
  logic             sat_a_msb;
  logic [WIDTH-1:0] sat_y;

  always_comb begin
    sat_y = acc_r;
    if (sat_v) sat_y = sat_a_msb ? MIN_NEG : MAX_POS;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      acc_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= '0;
      z       <= 1'b0;
      c       <= 1'b0;
      v       <= 1'b0;
      n       <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_c     <= 1'b0;
      sat_v     <= 1'b0;
      sat_a_msb <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= op[0] ? ~b : b;
            carry_r <= op[1] ? c : op[0];
            cnt     <= '0;
            acc_r   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          carry_r <= cout;
          acc_r   <= acc_next;
          cnt     <= cnt + CW'(1);
          if (last) begin
            cnt <= '0;
`ifdef ADDSUB_SAT_EN
            sat_c     <= cout;
            sat_v     <= ovf;
            sat_a_msb <= a_r[CHUNK-1];
            state     <= SAT;
`else
            y     <= acc_next;
            c     <= cout;
            v     <= ovf;
            n     <= acc_next[WIDTH-1];
            z     <= (acc_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end
        end
`ifdef ADDSUB_SAT_EN
        SAT: begin
          // c/v/n describe the wrapped result; only y and z see the clamp.
          y     <= sat_y;
          z     <= (sat_y == '0);
          c     <= sat_c;
          v     <= sat_v;
          n     <= acc_r[WIDTH-1];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
